// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the data memory between the CPU MEM stage and a
// debug/loader port. The CPU has priority. A waiting debug request is
// granted on the first CPU-idle cycle. If it has waited too long, the CPU is
// stalled for one cycle so that the debug access can be forced through.
module dmem_arbiter #(
    parameter int WIDTH    = 32,
    parameter int ADDR_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              cpu_mem_write_i,
    input  logic              cpu_mem_read_i,
    input  logic [ADDR_W-1:0] cpu_addr_i,
    input  logic [WIDTH-1:0]  cpu_wdata_i,
    output logic [WIDTH-1:0]  cpu_rdata_o,
    output logic              cpu_stall_o,
    input  logic              dbg_req_i,
    input  logic              dbg_we_i,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    input  logic [WIDTH-1:0]  dbg_wdata_i,
    output logic              dbg_gnt_o,
    output logic              dbg_rvalid_o,
    output logic [WIDTH-1:0]  dbg_rdata_o,
    output logic              mem_write_o,
    output logic              mem_read_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [WIDTH-1:0]  mem_wdata_o,
    input  logic [WIDTH-1:0]  mem_rdata_i
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_rvalid;
    logic [WIDTH-1:0]  r_rdata;

    logic              w_cpu_acc;
    logic              w_force;
    logic              w_grant;

    assign w_cpu_acc = cpu_mem_write_i | cpu_mem_read_i;
    // The stall comes from the registered state, so the CPU sees it at the start of the cycle.
    assign w_force   = (r_state == ST_FORCE);
    assign w_grant   = rst_n_i & dbg_req_i & (w_force | ~w_cpu_acc);

    assign cpu_rdata_o  = mem_rdata_i;
    assign cpu_stall_o  = w_force;
    assign dbg_gnt_o    = w_grant;
    assign dbg_rvalid_o = r_rvalid;
    assign dbg_rdata_o  = r_rdata;

    // Memory port mux: debug on a grant, nothing while the CPU is stalled, otherwise the CPU.
    always_comb begin
        mem_write_o = 1'b0;
        mem_read_o  = 1'b0;
        mem_addr_o  = cpu_addr_i;
        mem_wdata_o = cpu_wdata_i;
        if (w_grant) begin
            mem_write_o = dbg_we_i;
            mem_read_o  = ~dbg_we_i;
            mem_addr_o  = dbg_addr_i;
            mem_wdata_o = dbg_wdata_i;
        end else if (w_force) begin
            // The stalled CPU replays this access next cycle.
            mem_write_o = 1'b0;
            mem_read_o  = 1'b0;
        end else begin
            mem_write_o = rst_n_i & cpu_mem_write_i;
            mem_read_o  = rst_n_i & cpu_mem_read_i;
        end
    end

    // Arbitration FSM and wait counter that bounds how long debug can starve.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (dbg_req_i && !w_grant) begin
                        r_state <= ST_WAIT;
                        r_cnt   <= CW'(1);
                    end else begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                end
                ST_WAIT: begin
                    if (w_grant || !dbg_req_i) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (r_cnt == CW'(MAX_WAIT)) begin
                        r_state <= ST_FORCE;
                    end else begin
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                ST_FORCE: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Capture debug read data at the end of a read grant; rvalid pulses for one cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
        end else if (w_grant && !dbg_we_i) begin
            r_rvalid <= 1'b1;
            r_rdata  <= mem_rdata_i;
        end else begin
            r_rvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed self-checking bench for dmem_arbiter with a small behavioural memory.
module tb_dmem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        cpu_mem_write_i, cpu_mem_read_i;
    logic [31:0] cpu_addr_i, cpu_wdata_i, cpu_rdata_o;
    logic        cpu_stall_o;
    logic        dbg_req_i, dbg_we_i;
    logic [31:0] dbg_addr_i, dbg_wdata_i;
    logic        dbg_gnt_o, dbg_rvalid_o;
    logic [31:0] dbg_rdata_o;
    logic        mem_write_o, mem_read_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;

    logic [31:0] mem [0:63];
    logic [5:0]  w_idx;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_arbiter #(.WIDTH(32), .ADDR_W(32), .MAX_WAIT(8)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i),
        .cpu_mem_write_i(cpu_mem_write_i), .cpu_mem_read_i(cpu_mem_read_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i), .cpu_rdata_o(cpu_rdata_o),
        .cpu_stall_o(cpu_stall_o),
        .dbg_req_i(dbg_req_i), .dbg_we_i(dbg_we_i), .dbg_addr_i(dbg_addr_i),
        .dbg_wdata_i(dbg_wdata_i), .dbg_gnt_o(dbg_gnt_o), .dbg_rvalid_o(dbg_rvalid_o),
        .dbg_rdata_o(dbg_rdata_o),
        .mem_write_o(mem_write_o), .mem_read_o(mem_read_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    // Behavioural D_memory: combinational read, write at the rising edge.
    assign w_idx       = mem_addr_o[5:0];
    assign mem_rdata_i = mem[w_idx];
    always @(posedge clk_i) begin
        if (mem_write_o) mem[w_idx] <= mem_wdata_o;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge (input-drive point).
    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    // Advance to the falling edge (sample point for this cycle's outputs).
    task automatic at_neg();
        @(negedge clk_i);
    endtask

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'd0;
        mem[21] = 32'd7;
        rst_n_i = 1'b0;
        cpu_mem_write_i = 1'b0; cpu_mem_read_i = 1'b0;
        cpu_addr_i = 32'd0; cpu_wdata_i = 32'd0;
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'd60; dbg_wdata_i = 32'd3;

        // 1: reset with a pending debug request and idle CPU
        at_neg();
        check("rst_gnt",    {31'd0, dbg_gnt_o},    32'd0);
        check("rst_mwr",    {31'd0, mem_write_o},  32'd0);
        check("rst_stall",  {31'd0, cpu_stall_o},  32'd0);
        check("rst_rvalid", {31'd0, dbg_rvalid_o}, 32'd0);
        check("rst_rdata",  dbg_rdata_o,           32'd0);
        step();
        check("rst_mem60",  mem[60],               32'd0);
        dbg_req_i = 1'b0;
        rst_n_i   = 1'b1;
        step();

        // 2: debug write, CPU idle -> same-cycle grant
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'd20; dbg_wdata_i = 32'd5;
        at_neg();
        check("wr_gnt",  {31'd0, dbg_gnt_o},   32'd1);
        check("wr_mwr",  {31'd0, mem_write_o}, 32'd1);
        check("wr_addr", mem_addr_o,           32'd20);
        step();
        dbg_req_i = 1'b0;
        check("wr_mem20", mem[20],                  32'd5);
        check("wr_state", 32'(int'(dut.r_state)),   32'd0);
        check("wr_norv",  {31'd0, dbg_rvalid_o},    32'd0);

        // 3: debug read addr 21 -> rvalid/rdata one cycle after grant
        dbg_req_i = 1'b1; dbg_we_i = 1'b0; dbg_addr_i = 32'd21;
        at_neg();
        check("rd_gnt",  {31'd0, dbg_gnt_o},  32'd1);
        check("rd_mrd",  {31'd0, mem_read_o}, 32'd1);
        step();
        dbg_req_i = 1'b0;
        at_neg();
        check("rd_rvalid1", {31'd0, dbg_rvalid_o}, 32'd1);
        check("rd_rdata",   dbg_rdata_o,           32'd7);
        step();
        at_neg();
        check("rd_rvalid2", {31'd0, dbg_rvalid_o}, 32'd0);
        check("rd_hold",    dbg_rdata_o,           32'd7);
        step();

        // 4: CPU writes every cycle; debug forced after the wait budget
        cpu_mem_write_i = 1'b1; cpu_addr_i = 32'd30; cpu_wdata_i = 32'd99;
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'd40; dbg_wdata_i = 32'h55;
        for (int c = 0; c < 9; c++) begin
            at_neg();
            check($sformatf("frc_nognt%0d", c),  {31'd0, dbg_gnt_o},   32'd0);
            check($sformatf("frc_nostl%0d", c),  {31'd0, cpu_stall_o}, 32'd0);
            step();
            if (c == 8) begin
                cpu_addr_i = 32'd31; cpu_wdata_i = 32'd77;
            end
        end
        check("frc_cpu30", mem[30], 32'd99);
        at_neg();
        check("frc_stall", {31'd0, cpu_stall_o}, 32'd1);
        check("frc_gnt",   {31'd0, dbg_gnt_o},   32'd1);
        check("frc_addr",  mem_addr_o,           32'd40);
        step();
        dbg_req_i = 1'b0;
        check("frc_mem40",  mem[40], 32'h55);
        check("frc_nocpu",  mem[31], 32'd0);
        at_neg();
        check("frc_unstall", {31'd0, cpu_stall_o}, 32'd0);
        check("frc_cpuwr",   {31'd0, mem_write_o}, 32'd1);
        step();
        cpu_mem_write_i = 1'b0;
        check("frc_replay", mem[31], 32'd77);

        // 5: CPU reads in N, idle in N+1 -> debug waits one cycle, no stall
        cpu_mem_read_i = 1'b1; cpu_addr_i = 32'd22;
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'd23; dbg_wdata_i = 32'd9;
        at_neg();
        check("w1_nognt", {31'd0, dbg_gnt_o},   32'd0);
        check("w1_nostl", {31'd0, cpu_stall_o}, 32'd0);
        step();
        cpu_mem_read_i = 1'b0;
        check("w1_state", 32'(int'(dut.r_state)), 32'd1);
        at_neg();
        check("w1_gnt",   {31'd0, dbg_gnt_o},   32'd1);
        check("w1_nostl2", {31'd0, cpu_stall_o}, 32'd0);
        step();
        dbg_req_i = 1'b0;
        check("w1_idle",  32'(int'(dut.r_state)), 32'd0);
        check("w1_cnt",   32'(dut.r_cnt),         32'd0);
        check("w1_mem23", mem[23],                32'd9);

        // 6: async reset while waiting with cnt=5
        cpu_mem_read_i = 1'b1; cpu_addr_i = 32'd1;
        dbg_req_i = 1'b1; dbg_we_i = 1'b1; dbg_addr_i = 32'd50; dbg_wdata_i = 32'hAA;
        for (int c = 0; c < 5; c++) begin
            at_neg();
            check($sformatf("ar_nostl%0d", c), {31'd0, cpu_stall_o}, 32'd0);
            step();
        end
        check("ar_wait", 32'(int'(dut.r_state)), 32'd1);
        check("ar_cnt5", 32'(dut.r_cnt),         32'd5);
        #2;
        rst_n_i = 1'b0;
        #1;
        check("ar_idle",  32'(int'(dut.r_state)), 32'd0);
        check("ar_cnt0",  32'(dut.r_cnt),         32'd0);
        check("ar_gnt",   {31'd0, dbg_gnt_o},     32'd0);
        check("ar_mwr",   {31'd0, mem_write_o},   32'd0);
        check("ar_stall", {31'd0, cpu_stall_o},   32'd0);
        step();
        step();
        check("ar_mem50", mem[50], 32'd0);
        dbg_req_i = 1'b0; cpu_mem_read_i = 1'b0;
        rst_n_i = 1'b1;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
